// File: rtl/usb_txn_ctrl.sv
// USB full-speed transaction sequencer: decodes host packets, picks the device
// response and decides which block owns the shared 64-byte data buffer.
module usb_txn_ctrl #(
   parameter int TIMEOUT_CYCLES = 162,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] rx_packet,
   input  logic       rx_data_ready,
   input  logic       rx_transfer_active,
   input  logic       rx_error,
   input  logic       tx_transfer_active,
   input  logic       tx_error,
   input  logic [6:0] buffer_occupancy,
   input  logic       tx_arm,
   output logic [2:0] tx_packet,
   output logic       tx_start,
   output logic [1:0] d_mode,
   output logic       clear,
   output logic       txn_done,
   output logic       txn_in,
   output logic       timeout_err,
   output logic       busy
);

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_OUT_WAIT    = 3'd1;
   localparam logic [2:0] S_ACK_TX      = 3'd2;
   localparam logic [2:0] S_IN_TX       = 3'd3;
   localparam logic [2:0] S_IN_WAIT_ACK = 3'd4;
   localparam logic [2:0] S_NAK_TX      = 3'd5;

   localparam logic [2:0] PKT_OUT  = 3'd1;
   localparam logic [2:0] PKT_IN   = 3'd2;
   localparam logic [2:0] PKT_DATA = 3'd3;
   localparam logic [2:0] PKT_ACK  = 3'd4;

   localparam logic [2:0] TX_DATA0 = 3'd1;
   localparam logic [2:0] TX_DATA1 = 3'd2;
   localparam logic [2:0] TX_ACK   = 3'd3;
   localparam logic [2:0] TX_NAK   = 3'd4;

   localparam logic [1:0] DM_AHB = 2'd0;
   localparam logic [1:0] DM_RX  = 2'd1;
   localparam logic [1:0] DM_TX  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TX_RISE_MAX = CNT_W'(2);

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_toggle;
   logic             r_txSeen;
   logic             r_startPend;

   logic [2:0] w_next;
   logic [2:0] w_txPacket;
   logic [1:0] w_dMode;
   logic       w_txStart;
   logic       w_clear;
   logic       w_txnDone;
   logic       w_txnIn;
   logic       w_timeoutErr;
   logic       w_toggle;
   logic       w_startPend;
   logic       w_cntInc;
   logic       w_cntClr;
   logic       w_rxPkt;
   logic       w_timeout;
   logic       w_txFall;
   logic       w_txFail;

   assign w_rxPkt   = rx_data_ready && !rx_error;
   assign w_timeout = (r_cnt == CNT_MAX);
   assign w_txFall  = r_txSeen && !tx_transfer_active;
   // A TX that never raises tx_transfer_active shortly after tx_start is treated as aborted.
   assign w_txFail  = tx_error ||
                      (!r_startPend && !r_txSeen && !tx_transfer_active && (r_cnt == TX_RISE_MAX));

   always_comb begin
      w_next       = r_state;
      w_txPacket   = tx_packet;
      w_txStart    = 1'b0;
      w_clear      = 1'b0;
      w_txnDone    = 1'b0;
      w_txnIn      = txn_in;
      w_dMode      = d_mode;
      w_timeoutErr = timeout_err;
      w_toggle     = r_toggle;
      w_startPend  = r_startPend;
      w_cntInc     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rxPkt && rx_packet == PKT_OUT) begin
               w_clear      = 1'b1;
               w_dMode      = DM_RX;
               w_timeoutErr = 1'b0;
               w_next       = S_OUT_WAIT;
            end else if (w_rxPkt && rx_packet == PKT_IN) begin
               w_txStart   = !rx_transfer_active;
               w_startPend = rx_transfer_active;
               if (tx_arm && buffer_occupancy != 7'd0) begin
                  w_txPacket   = r_toggle ? TX_DATA1 : TX_DATA0;
                  w_dMode      = DM_TX;
                  w_timeoutErr = 1'b0;
                  w_next       = S_IN_TX;
               end else begin
                  w_txPacket = TX_NAK;
                  w_next     = S_NAK_TX;
               end
            end
         end
         S_OUT_WAIT: begin
            w_cntInc = !rx_transfer_active;
            if (rx_error || (rx_data_ready && rx_packet != PKT_DATA)) begin
               w_clear = 1'b1;
               w_dMode = DM_AHB;
               w_next  = S_IDLE;
            end else if (rx_data_ready) begin
               w_txPacket  = TX_ACK;
               w_txStart   = !rx_transfer_active;
               w_startPend = rx_transfer_active;
               w_next      = S_ACK_TX;
            end else if (w_timeout) begin
               w_timeoutErr = 1'b1;
               w_clear      = 1'b1;
               w_dMode      = DM_AHB;
               w_next       = S_IDLE;
            end
         end
         S_ACK_TX, S_IN_TX, S_NAK_TX: begin
            w_cntInc = !r_startPend;
            // A deferred launch waits until the receiver has gone quiet.
            if (r_startPend && !rx_transfer_active) begin
               w_txStart   = 1'b1;
               w_startPend = 1'b0;
            end
            if (w_txFail) begin
               w_txStart   = 1'b0;
               w_startPend = 1'b0;
               w_clear     = (r_state == S_ACK_TX);
               w_dMode     = DM_AHB;
               w_next      = S_IDLE;
            end else if (w_txFall) begin
               if (r_state == S_ACK_TX) begin
                  w_txnDone = 1'b1;
                  w_txnIn   = 1'b0;
                  w_dMode   = DM_AHB;
                  w_next    = S_IDLE;
               end else if (r_state == S_IN_TX) begin
                  w_next = S_IN_WAIT_ACK;
               end else begin
                  w_next = S_IDLE;
               end
            end
         end
         S_IN_WAIT_ACK: begin
            w_cntInc = !rx_transfer_active;
            if (w_rxPkt && rx_packet == PKT_ACK) begin
               w_toggle  = !r_toggle;
               w_clear   = 1'b1;
               w_txnDone = 1'b1;
               w_txnIn   = 1'b1;
               w_dMode   = DM_AHB;
               w_next    = S_IDLE;
            end else if (rx_error || rx_data_ready) begin
               w_dMode = DM_AHB;
               w_next  = S_IDLE;
            end else if (w_timeout) begin
               w_timeoutErr = 1'b1;
               w_dMode      = DM_AHB;
               w_next       = S_IDLE;
            end
         end
         default: begin
            w_dMode = DM_AHB;
            w_next  = S_IDLE;
         end
      endcase
   end

   assign w_cntClr = (w_next != r_state) || (r_startPend && !w_startPend);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_toggle    <= 1'b0;
         r_txSeen    <= 1'b0;
         r_startPend <= 1'b0;
         tx_packet   <= 3'd0;
         tx_start    <= 1'b0;
         d_mode      <= DM_AHB;
         clear       <= 1'b0;
         txn_done    <= 1'b0;
         txn_in      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_toggle    <= w_toggle;
         r_startPend <= w_startPend;
         tx_packet   <= w_txPacket;
         tx_start    <= w_txStart;
         d_mode      <= w_dMode;
         clear       <= w_clear;
         txn_done    <= w_txnDone;
         txn_in      <= w_txnIn;
         timeout_err <= w_timeoutErr;
         if (w_cntClr) begin
            r_cnt <= '0;
         end else if (w_cntInc && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_txSeen <= (w_next != r_state) ? 1'b0
                                         : (r_txSeen || (tx_transfer_active && !r_startPend));
      end
   end

   assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Randomized bench for usb_txn_ctrl; a transaction-level model tracks the
// data toggle and sticky timeout flag and predicts every response.
module tb_usb_txn_ctrl;

   localparam int T = 162;

   localparam logic [2:0] PKT_NONE  = 3'd0;
   localparam logic [2:0] PKT_OUT   = 3'd1;
   localparam logic [2:0] PKT_IN    = 3'd2;
   localparam logic [2:0] PKT_DATA  = 3'd3;
   localparam logic [2:0] PKT_ACK   = 3'd4;
   localparam logic [2:0] PKT_NAK   = 3'd5;
   localparam logic [2:0] PKT_STALL = 3'd6;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [2:0] rx_packet;
   logic       rx_data_ready;
   logic       rx_transfer_active;
   logic       rx_error;
   logic       tx_transfer_active;
   logic       tx_error;
   logic [6:0] buffer_occupancy;
   logic       tx_arm;
   logic [2:0] tx_packet;
   logic       tx_start;
   logic [1:0] d_mode;
   logic       clear;
   logic       txn_done;
   logic       txn_in;
   logic       timeout_err;
   logic       busy;

   int testsRun    = 0;
   int testsFailed = 0;
   bit mToggle     = 1'b0;
   bit mTimeoutErr = 1'b0;

   always #5 clk = ~clk;

   usb_txn_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
      .clk               (clk),
      .n_rst             (n_rst),
      .rx_packet         (rx_packet),
      .rx_data_ready     (rx_data_ready),
      .rx_transfer_active(rx_transfer_active),
      .rx_error          (rx_error),
      .tx_transfer_active(tx_transfer_active),
      .tx_error          (tx_error),
      .buffer_occupancy  (buffer_occupancy),
      .tx_arm            (tx_arm),
      .tx_packet         (tx_packet),
      .tx_start          (tx_start),
      .d_mode            (d_mode),
      .clear             (clear),
      .txn_done          (txn_done),
      .txn_in            (txn_in),
      .timeout_err       (timeout_err),
      .busy              (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] pkt, input bit err);
      rx_packet     = pkt;
      rx_data_ready = err ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_error      = err;
      tick();
      rx_packet     = PKT_NONE;
      rx_data_ready = 1'b0;
      rx_error      = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) tick();
   endtask

   function automatic int pickTxMode();
      int r = $urandom_range(0, 7);
      return (r == 7) ? 2 : ((r == 6) ? 1 : 0);
   endfunction

   // TX emulation: mode 0 sends normally, 1 aborts mid-packet, 2 never starts.
   task automatic runTx(input int mode, output bit sawClear);
      int len = $urandom_range(3, 25);
      sawClear = 1'b0;
      if (mode == 2) begin
         for (int i = 0; i < 8 && busy; i++) begin
            tick();
            sawClear |= clear;
         end
      end else begin
         tx_transfer_active = 1'b1;
         repeat ((mode == 1) ? len / 2 : len) tick();
         if (mode == 1) tx_error = 1'b1;
         else tx_transfer_active = 1'b0;
         tick();
         tx_error           = 1'b0;
         tx_transfer_active = 1'b0;
         sawClear           = clear;
      end
   endtask

   // mode 0 DATA, 1 rx_error, 2 unexpected packet; the host stays silent for
   // d cycles, then its packet occupies the line for L cycles.
   task automatic doOut(input int d, input int L, input int mode, input int txMode);
      bit expTimeout = (d > T) || (d == T && L > 0);
      bit sawClear;
      logic [2:0] wrong[5] = '{PKT_OUT, PKT_IN, PKT_ACK, PKT_NAK, PKT_STALL};
      checkOutput("terr_sticky", timeout_err, mTimeoutErr);
      applyStimulus(PKT_OUT, 1'b0);
      mTimeoutErr = 1'b0;
      checkOutput("out_clear", clear, 1);
      checkOutput("out_dmode_rx", d_mode, 1);
      checkOutput("out_terr_cleared", timeout_err, mTimeoutErr);
      if (expTimeout) begin
         idleCycles(T);
         checkOutput("out_busy_before_timeout", busy, 1);
         tick();
         mTimeoutErr = 1'b1;
         checkOutput("out_timeout_err", timeout_err, 1);
         checkOutput("out_timeout_clear", clear, 1);
         checkOutput("out_timeout_dmode", d_mode, 0);
         checkOutput("out_timeout_idle", busy, 0);
         return;
      end
      idleCycles(d);
      if (L > 0) begin
         rx_transfer_active = 1'b1;
         idleCycles(L);
         rx_transfer_active = 1'b0;
      end
      checkOutput("out_still_waiting", busy, 1);
      if (mode == 0) begin
         applyStimulus(PKT_DATA, 1'b0);
         checkOutput("ack_tx_start", tx_start, 1);
         checkOutput("ack_tx_packet", tx_packet, 3);
         checkOutput("ack_dmode_rx", d_mode, 1);
         runTx(txMode, sawClear);
         if (txMode == 0) begin
            checkOutput("out_txn_done", txn_done, 1);
            checkOutput("out_txn_in", txn_in, 0);
            checkOutput("out_done_noclear", clear, 0);
         end else begin
            checkOutput("ack_fail_nodone", txn_done, 0);
            checkOutput("ack_fail_clear", sawClear, 1);
         end
      end else begin
         applyStimulus((mode == 1) ? 3'($urandom_range(0, 6)) : wrong[$urandom_range(0, 4)],
                       mode == 1);
         checkOutput("out_abort_clear", clear, 1);
         checkOutput("out_abort_nostart", tx_start, 0);
      end
      checkOutput("out_end_dmode", d_mode, 0);
      checkOutput("out_end_idle", busy, 0);
   endtask

   // resp 0 ACK, 1 rx_error, 2 other packet, 3 silence until timeout.
   task automatic doIn(input bit arm, input int occ, input int txMode, input int resp);
      bit sawClear;
      tx_arm           = arm;
      buffer_occupancy = 7'(occ);
      checkOutput("terr_sticky", timeout_err, mTimeoutErr);
      applyStimulus(PKT_IN, 1'b0);
      checkOutput("in_tx_start", tx_start, 1);
      if (arm && occ > 0) begin
         mTimeoutErr = 1'b0;
         checkOutput("in_data_pid", tx_packet, mToggle ? 2 : 1);
         checkOutput("in_dmode_tx", d_mode, 2);
         checkOutput("in_terr_cleared", timeout_err, 0);
         runTx(txMode, sawClear);
         if (txMode != 0) begin
            checkOutput("in_txfail_idle", busy, 0);
            checkOutput("in_txfail_dmode", d_mode, 0);
            checkOutput("in_txfail_keepbuf", sawClear, 0);
         end else begin
            checkOutput("in_wait_busy", busy, 1);
            checkOutput("in_wait_dmode", d_mode, 2);
            if (resp == 3) begin
               idleCycles(T + 1);
               mTimeoutErr = 1'b1;
               checkOutput("in_timeout_err", timeout_err, 1);
            end else begin
               idleCycles($urandom_range(0, 100));
               if (resp == 0) applyStimulus(PKT_ACK, 1'b0);
               else if (resp == 1) applyStimulus(3'($urandom_range(0, 6)), 1'b1);
               else applyStimulus($urandom_range(0, 1) ? PKT_NAK : PKT_DATA, 1'b0);
            end
            checkOutput("in_done", txn_done, resp == 0);
            checkOutput("in_clear", clear, resp == 0);
            if (resp == 0) begin
               checkOutput("in_txn_in", txn_in, 1);
               mToggle = !mToggle;
            end
            checkOutput("in_end_dmode", d_mode, 0);
            checkOutput("in_end_idle", busy, 0);
         end
      end else begin
         checkOutput("nak_pid", tx_packet, 4);
         checkOutput("nak_dmode", d_mode, 0);
         runTx(txMode, sawClear);
         checkOutput("nak_nodone", txn_done, 0);
         checkOutput("nak_idle", busy, 0);
         checkOutput("nak_terr_kept", timeout_err, mTimeoutErr);
      end
      tx_arm = 1'b0;
   endtask

   task automatic doJunk();
      logic [2:0] ignored[5] = '{PKT_NONE, PKT_DATA, PKT_ACK, PKT_NAK, PKT_STALL};
      if ($urandom_range(0, 1)) applyStimulus(3'($urandom_range(0, 6)), 1'b1);
      else applyStimulus(ignored[$urandom_range(0, 4)], 1'b0);
      checkOutput("junk_idle", busy, 0);
      checkOutput("junk_nostart", tx_start, 0);
      checkOutput("junk_noclear", clear, 0);
      checkOutput("junk_dmode", d_mode, 0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_tx_packet"}, tx_packet, 0);
      checkOutput({tag, "_tx_start"}, tx_start, 0);
      checkOutput({tag, "_d_mode"}, d_mode, 0);
      checkOutput({tag, "_clear"}, clear, 0);
      checkOutput({tag, "_txn_done"}, txn_done, 0);
      checkOutput({tag, "_txn_in"}, txn_in, 0);
      checkOutput({tag, "_timeout_err"}, timeout_err, 0);
      checkOutput({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      n_rst              = 1'b0;
      rx_packet          = PKT_NONE;
      rx_data_ready      = 1'b0;
      rx_transfer_active = 1'b0;
      rx_error           = 1'b0;
      tx_transfer_active = 1'b0;
      tx_error           = 1'b0;
      buffer_occupancy   = 7'd0;
      tx_arm             = 1'b0;
      idleCycles(3);
      checkResetState("por");
      n_rst = 1'b1;
      tick();

      doOut(20, 40, 0, 0);
      doIn(1'b1, 8, 0, 0);
      doIn(1'b1, 8, 0, 0);
      doIn(1'b0, 8, 0, 0);
      doIn(1'b1, 0, 0, 0);
      doOut(T + 1, 0, 0, 0);
      doJunk();
      doOut(10, 0, 0, 0);
      doIn(1'b1, 8, 0, 1);
      doIn(1'b1, 8, 0, 0);
      doIn(1'b1, 64, 0, 3);
      doOut(T, 0, 0, 0);
      doOut(T - 1, 30, 0, 0);
      doOut(100, 80, 0, 0);
      doOut(5, 0, 0, 2);
      doOut(5, 0, 0, 1);
      doIn(1'b1, 8, 2, 0);
      doIn(1'b1, 8, 1, 0);
      doOut(7, 0, 1, 0);
      doOut(7, 0, 2, 0);

      // Reset in the middle of OUT_WAIT, with the toggle left at 1 beforehand.
      if (!mToggle) doIn(1'b1, 8, 0, 0);
      applyStimulus(PKT_OUT, 1'b0);
      idleCycles(5);
      n_rst = 1'b0;
      tick();
      checkResetState("rst_mid");
      tick();
      checkResetState("rst_hold");
      n_rst       = 1'b1;
      mToggle     = 1'b0;
      mTimeoutErr = 1'b0;
      tick();
      doIn(1'b1, 8, 0, 0);

      for (int i = 0; i < 40; i++) begin
         int kind = $urandom_range(0, 4);
         if (kind <= 1) begin
            doOut(($urandom_range(0, 3) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 120),
                  $urandom_range(0, 1) ? 0 : $urandom_range(1, 80),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                  pickTxMode());
         end else if (kind <= 3) begin
            doIn($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 64),
                 pickTxMode(),
                 ($urandom_range(0, 4) <= 1) ? 0 : $urandom_range(1, 3));
         end else begin
            doJunk();
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/usb_txn_ctrl.md
Name: usb_txn_ctrl

Overview:
Transaction-level sequencer for the USB full-speed endpoint. It sits between usb_rx, the USB TX encoder, the shared 64-byte data buffer and the AHB-lite register slave. It decodes received token, data and handshake packets, decides the device response (ACK, NAK or DATA0/1), and grants data-buffer ownership to exactly one of AHB, RX or TX. It also enforces the bus-turnaround timeout.

Parameters:
TIMEOUT_CYCLES, 162, clocks to wait for host DATA/ACK after OUT token or after our DATA (18 bit-times at 9 clk/bit)
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, 108 MHz
n_rst  in  1  synchronous active-low reset
rx_packet  in  3  from usb_rx: 0 NONE, 1 OUT, 2 IN, 3 DATA, 4 ACK, 5 NAK, 6 STALL
rx_data_ready  in  1  from usb_rx: 1-cycle pulse, rx_packet valid and packet error-free
rx_transfer_active  in  1  from usb_rx: packet reception in progress
rx_error  in  1  from usb_rx: bad sync/PID/CRC/EOP on last packet
tx_transfer_active  in  1  from TX: packet transmission in progress
tx_error  in  1  from TX: transmission aborted
buffer_occupancy  in  7  shared buffer fill level, 0..64
tx_arm  in  1  from AHB regs: software has loaded IN data (level)
tx_packet  out  3  to TX: 0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK
tx_start  out  1  1-cycle pulse launching tx_packet
d_mode  out  2  buffer owner: 0 AHB, 1 RX, 2 TX
clear  out  1  1-cycle buffer flush pulse
txn_done  out  1  1-cycle pulse: transaction completed successfully
txn_in  out  1  direction of last completed txn (1 = IN), valid with txn_done
timeout_err  out  1  sticky; cleared by next accepted token
busy  out  1  state != IDLE

Behaviour:
- Reset (n_rst low at posedge): state IDLE, counter 0, data toggle 0, tx_packet 0, tx_start 0, d_mode 0, clear 0, txn_done 0, txn_in 0, timeout_err 0, busy 0. Reset mid-transaction returns to IDLE in one cycle; no tx_start is issued.
- All outputs are registered; the response appears one cycle after the triggering input.
- IDLE:
  - rx_data_ready with OUT: clear pulse, d_mode=RX, clear timeout_err, go to OUT_WAIT.
  - rx_data_ready with IN and tx_arm=1 and buffer_occupancy>0: d_mode=TX, tx_packet=DATA0/1 per toggle, tx_start, clear timeout_err, go to IN_TX.
  - rx_data_ready with IN and no data: tx_packet=NAK, tx_start, go to NAK_TX.
  - Any other packet, or rx_error: ignored, d_mode stays AHB.
- OUT_WAIT: counter increments each cycle while rx_transfer_active=0.
  - rx_data_ready with DATA: tx_packet=ACK, tx_start, go to ACK_TX.
  - rx_error, or any non-DATA packet: clear pulse, d_mode=AHB, go to IDLE with no response.
  - Counter reaches TIMEOUT_CYCLES: timeout_err=1, clear pulse, d_mode=AHB, go to IDLE.
- ACK_TX: wait for tx_transfer_active to rise and then fall.
  - Fall with no tx_error: txn_done, txn_in=0, d_mode=AHB, go to IDLE.
  - tx_error: clear pulse, d_mode=AHB, go to IDLE.
- IN_TX: on tx_transfer_active fall, go to IN_WAIT_ACK with counter reset. tx_error goes to IDLE with d_mode=AHB and the buffer retained.
- IN_WAIT_ACK:
  - rx_data_ready with ACK: toggle flips, clear pulse, txn_done, txn_in=1, d_mode=AHB, go to IDLE.
  - Timeout, rx_error or another packet: toggle unchanged, buffer retained (no clear), d_mode=AHB, go to IDLE. Timeout also sets timeout_err.
- NAK_TX: on tx_transfer_active fall, go to IDLE.
- TX completion detection: TX must raise tx_transfer_active within 2 cycles of tx_start. If it does not, treat as tx_error.
- rx_error and rx_data_ready in the same cycle: rx_error wins.
- Counter saturates at TIMEOUT_CYCLES and clears on every state change.
- tx_start is never asserted while rx_transfer_active=1.

Test Plan:
- Reset held 2 cycles mid-OUT_WAIT -> all outputs 0, d_mode=0 on the next cycle; no tx_start.
- OUT token, then DATA with 4 bytes within 100 cycles -> clear pulse, d_mode=1, then tx_packet=3 with tx_start. TX active for 20 cycles -> txn_done with txn_in=0, d_mode=0.
- IN token, tx_arm=1, occupancy=8 -> tx_packet=1 (DATA0), d_mode=2; host ACK -> txn_done with txn_in=1, clear pulse. Second IN -> tx_packet=2 (DATA1).
- IN token, tx_arm=0 -> tx_packet=4 (NAK), d_mode stays 0, no txn_done.
- OUT token, then no DATA for 162 cycles -> timeout_err=1, clear pulse, state IDLE. Next OUT token -> timeout_err=0.
- IN with DATA sent, then host response has rx_error -> no toggle flip, no clear, occupancy untouched. Retry IN -> DATA0 again.
